// File: rtl/core_rrv_kbd_ps2_rx.sv
// core_rrv_kbd_ps2_rx: PS/2 keyboard receiver; ports kbd_clk/rst_n, raw ps2_clk/ps2_data in, write_en/data_in byte strobe, frame_err pulse, busy
module core_rrv_kbd_ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       kbd_clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       write_en,
  output logic [7:0] data_in,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic clk_s1, s_clk, data_s1, s_data;
  logic filt_clk, filt_d, fall_pulse;
  logic [3:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic parity, ok, to_exp;
  assign busy = state != IDLE;
  assign ok = s_data & ^{shreg, parity};
  // a fall_pulse in the expiry cycle restarts the count, so it wins
  assign to_exp = busy && to_cnt == TO_LAST && !fall_pulse;
  always_ff @(posedge kbd_clk or negedge rst_n)
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      s_clk <= 1'b1;
      data_s1 <= 1'b1;
      s_data <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      s_clk <= clk_s1;
      data_s1 <= ps2_data;
      s_data <= data_s1;
    end
  // filt_clk follows s_clk only after FILTER_LEN consecutive differing samples
  always_ff @(posedge kbd_clk or negedge rst_n)
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= 4'd0;
      filt_d <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      filt_clk <= (s_clk != filt_clk && filt_cnt == FL_LAST) ? s_clk : filt_clk;
      filt_cnt <= (s_clk == filt_clk || filt_cnt == FL_LAST) ? 4'd0 : filt_cnt + 4'd1;
      filt_d <= filt_clk;
      fall_pulse <= filt_d & ~filt_clk;
    end
  always_ff @(posedge kbd_clk or negedge rst_n)
    if (!rst_n) to_cnt <= '0;
    else to_cnt <= (fall_pulse || !busy) ? '0 : (to_cnt == '1 ? to_cnt : to_cnt + 1'b1);
  always_ff @(posedge kbd_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      shreg <= 8'h00;
      parity <= 1'b0;
      write_en <= 1'b0;
      frame_err <= 1'b0;
      data_in <= 8'h00;
    end else begin
      write_en <= 1'b0;
      frame_err <= 1'b0;
      if (to_exp) begin
        state <= IDLE;
        frame_err <= 1'b1;
      end else if (fall_pulse) begin
        case (state)
          IDLE: if (!s_data) begin
            bit_cnt <= 3'd0;
            state <= DATA;
          end
          DATA: begin
            shreg <= {s_data, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            state <= bit_cnt == 3'd7 ? PARITY : DATA;
          end
          PARITY: begin
            parity <= s_data;
            state <= STOP;
          end
          default: begin
            write_en <= ok;
            frame_err <= ~ok;
            data_in <= ok ? shreg : data_in;
            state <= IDLE;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_core_rrv_kbd_ps2_rx.sv
// tb_core_rrv_kbd_ps2_rx: directed bench for the PS/2 receiver
module tb_core_rrv_kbd_ps2_rx;
  localparam int FL = 4;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic we, fe, busy, we2, fe2, busy2;
  logic [7:0] din, din2;
  int n_tests = 0, n_fail = 0;
  int we_cnt = 0, fe_cnt = 0, we_wide = 0, fe_wide = 0, both = 0, we2_cnt = 0, fe2_cnt = 0;
  logic prev_we = 1'b0, prev_fe = 1'b0;
  logic [7:0] we_data [0:15];
  always #5 clk = ~clk;
  core_rrv_kbd_ps2_rx #(.FILTER_LEN(FL)) dut (
    .kbd_clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .write_en(we), .data_in(din), .frame_err(fe), .busy(busy));
  core_rrv_kbd_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(200)) dut_to (
    .kbd_clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .write_en(we2), .data_in(din2), .frame_err(fe2), .busy(busy2));
  always @(negedge clk) begin
    if (we) begin
      we_data[we_cnt % 16] = din;
      we_cnt++;
    end
    if (fe) fe_cnt++;
    if (we && prev_we) we_wide++;
    if (fe && prev_fe) fe_wide++;
    if (we && fe) both++;
    if (we2) we2_cnt++;
    if (fe2) fe2_cnt++;
    prev_we = we;
    prev_fe = fe;
  end
  function automatic logic [10:0] frame(input logic [7:0] b, input logic perr, input logic stop);
    return {stop, ~^b ^ perr, b, 1'b0};
  endfunction
  task automatic send_bit(input logic b, input int half);
    ps2_data = b;
    repeat (half) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (half) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [10:0] f, input int half);
    for (int i = 0; i < 11; i++) send_bit(f[i], half);
    ps2_data = 1'b1;
    repeat (FL + 20) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({we, fe, busy, din} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: got we=%b fe=%b busy=%b data=%h, want all 0", we, fe, busy, din);
    end
    n_tests++;
    if ({we2, fe2, busy2, din2} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_to: got we=%b fe=%b busy=%b data=%h, want all 0", we2, fe2, busy2, din2);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask
  task automatic test_good;
    int w0, f0;
    logic [10:0] f;
    w0 = we_cnt;
    f0 = fe_cnt;
    f = frame(8'h1C, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(f[i], 500);
    ps2_data = 1'b1;
    repeat (500) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (FL + 3) @(posedge clk);
    #1;
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: write_en=%b at FL+3, want 0", we);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (we !== 1'b1 || din !== 8'h1C) begin
      n_fail++;
      $display("FAIL latency: write_en=%b data=%h at FL+4, want 1 / 1c", we, din);
    end
    repeat (500 - FL - 4) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_tests++;
    if (we_cnt - w0 !== 1 || fe_cnt !== f0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL good_1c: strobes=%0d errs=%0d busy=%b, want 1 0 0", we_cnt - w0, fe_cnt - f0, busy);
    end
  endtask
  task automatic test_back_to_back;
    int w0;
    w0 = we_cnt;
    send_frame(frame(8'hF0, 1'b0, 1'b1), 100);
    send_frame(frame(8'h1C, 1'b0, 1'b1), 100);
    n_tests++;
    if (we_cnt - w0 !== 2 || we_data[w0 % 16] !== 8'hF0 || we_data[(w0 + 1) % 16] !== 8'h1C) begin
      n_fail++;
      $display("FAIL b2b: strobes=%0d bytes=%h %h, want 2 f0 1c", we_cnt - w0, we_data[w0 % 16], we_data[(w0 + 1) % 16]);
    end
    n_tests++;
    if (we_wide !== 0 || fe_wide !== 0 || both !== 0) begin
      n_fail++;
      $display("FAIL pulse_shape: wide_we=%0d wide_fe=%0d overlap=%0d, want 0 0 0", we_wide, fe_wide, both);
    end
  endtask
  task automatic test_parity_err;
    int w0, f0;
    w0 = we_cnt;
    f0 = fe_cnt;
    send_frame(frame(8'h1C, 1'b1, 1'b1), 100);
    n_tests++;
    if (fe_cnt - f0 !== 1 || we_cnt !== w0 || din !== 8'h1C) begin
      n_fail++;
      $display("FAIL parity_err: errs=%0d strobes=%0d data=%h, want 1 0 1c", fe_cnt - f0, we_cnt - w0, din);
    end
    send_frame(frame(8'h5A, 1'b0, 1'b1), 100);
    n_tests++;
    if (we_cnt - w0 !== 1 || din !== 8'h5A || fe_cnt - f0 !== 1) begin
      n_fail++;
      $display("FAIL after_parity: strobes=%0d data=%h errs=%0d, want 1 5a 1", we_cnt - w0, din, fe_cnt - f0);
    end
  endtask
  task automatic test_stop_err;
    int w0, f0;
    w0 = we_cnt;
    f0 = fe_cnt;
    send_frame(frame(8'h33, 1'b0, 1'b0), 100);
    n_tests++;
    if (fe_cnt - f0 !== 1 || we_cnt !== w0 || din !== 8'h5A) begin
      n_fail++;
      $display("FAIL stop_err: errs=%0d strobes=%0d data=%h, want 1 0 5a", fe_cnt - f0, we_cnt - w0, din);
    end
  endtask
  task automatic test_idle_start;
    int w0, f0;
    w0 = we_cnt;
    f0 = fe_cnt;
    send_bit(1'b1, 100);
    repeat (100) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || fe_cnt !== f0 || we_cnt !== w0) begin
      n_fail++;
      $display("FAIL idle_start: busy=%b errs=%0d strobes=%0d, want 0 0 0", busy, fe_cnt - f0, we_cnt - w0);
    end
  endtask
  task automatic test_glitch;
    int w0, f0;
    logic [10:0] f;
    w0 = we_cnt;
    f0 = fe_cnt;
    f = frame(8'hA7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(f[i], 100);
    repeat (40) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (FL - 1) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || fe_cnt !== f0) begin
      n_fail++;
      $display("FAIL glitch_mid: busy=%b errs=%0d, want 1 0", busy, fe_cnt - f0);
    end
    for (int i = 4; i < 11; i++) send_bit(f[i], 100);
    ps2_data = 1'b1;
    repeat (FL + 20) @(posedge clk);
    #1;
    n_tests++;
    if (we_cnt - w0 !== 1 || din !== 8'hA7 || fe_cnt !== f0) begin
      n_fail++;
      $display("FAIL glitch: strobes=%0d data=%h errs=%0d, want 1 a7 0", we_cnt - w0, din, fe_cnt - f0);
    end
  endtask
  task automatic test_reset_mid;
    int w0, f0;
    logic [10:0] f;
    w0 = we_cnt;
    f0 = fe_cnt;
    f = frame(8'h29, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(f[i], 100);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({we, fe, busy, din} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid: we=%b fe=%b busy=%b data=%h, want all 0", we, fe, busy, din);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_frame(f, 100);
    n_tests++;
    if (we_cnt - w0 !== 1 || din !== 8'h29 || fe_cnt !== f0) begin
      n_fail++;
      $display("FAIL after_reset: strobes=%0d data=%h errs=%0d, want 1 29 0", we_cnt - w0, din, fe_cnt - f0);
    end
  endtask
  task automatic test_timeout;
    int f0, w0;
    logic [10:0] f;
    repeat (300) @(posedge clk);
    #1;
    f0 = fe2_cnt;
    w0 = we2_cnt;
    f = frame(8'h1C, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(f[i], 50);
    ps2_data = f[4];
    repeat (50) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (50) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (FL + 203 - 50) @(posedge clk);
    #1;
    n_tests++;
    if (fe2 !== 1'b0 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: frame_err=%b busy=%b, want 0 1", fe2, busy2);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (fe2 !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: frame_err=%b, want 1", fe2);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (fe2 !== 1'b0 || busy2 !== 1'b0 || fe2_cnt - f0 !== 1 || we2_cnt !== w0) begin
      n_fail++;
      $display("FAIL timeout_after: frame_err=%b busy=%b errs=%0d strobes=%0d, want 0 0 1 0", fe2, busy2, fe2_cnt - f0, we2_cnt - w0);
    end
  endtask
  initial begin
    test_reset;
    test_good;
    test_back_to_back;
    test_parity_err;
    test_stop_err;
    test_idle_start;
    test_glitch;
    test_reset_mid;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
